// File: rtl/reg_bank.sv
// Register file with a per-register pending (scoreboard) bit for in-order issue.
// Optional macro REG_BANK_BYPASS_EN forwards same-cycle write-back data to the read ports.
module reg_bank #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEN,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              issueEN,
  input  logic [ADDR_W-1:0] issueAddr,
  input  logic [ADDR_W-1:0] rdAddrA,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic [DATA_W-1:0] dataA,
  output logic [DATA_W-1:0] dataB,
  output logic              busyA,
  output logic              busyB,
  output logic              stall
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_next;

  logic wr_live;
  logic byp_a;
  logic byp_b;
  logic byp_i;
  logic keep;
  logic waw;
  logic issue_ok;

  // Forwarding hits: a live write-back to the addressed register this cycle
  always_comb begin
    wr_live = wrEN & (wrAddr != '0);
`ifdef REG_BANK_BYPASS_EN
    byp_a = wr_live & (rdAddrA == wrAddr);
    byp_b = wr_live & (rdAddrB == wrAddr);
    byp_i = wr_live & (issueAddr == wrAddr);
`else
    byp_a = 1'b0;
    byp_b = 1'b0;
    byp_i = 1'b0;
`endif
    // A new producer issuing to the written register keeps it pending
    keep = issueEN & (issueAddr == wrAddr);
  end

  // Read ports, busy flags and stall; all forced quiet during reset
  always_comb begin
    dataA = '0;
    dataB = '0;
    busyA = 1'b0;
    busyB = 1'b0;
    waw   = 1'b0;
    stall = 1'b0;
    if (!rst) begin
      if (rdAddrA != '0) dataA = byp_a ? dataIn : regs[rdAddrA];
      if (rdAddrB != '0) dataB = byp_b ? dataIn : regs[rdAddrB];
      busyA = pending[rdAddrA] & ~(byp_a & ~keep);
      busyB = pending[rdAddrB] & ~(byp_b & ~keep);
      waw   = issueEN & pending[issueAddr] & ~(byp_i & ~keep);
      stall = busyA | busyB | waw;
    end
  end

  // Write-back clears, an accepted issue sets (set wins on the same address)
  always_comb begin
    issue_ok     = issueEN & ~stall & (issueAddr != '0);
    pending_next = pending;
    if (wrEN) pending_next[wrAddr] = 1'b0;
    if (issue_ok) pending_next[issueAddr] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      pending <= '0;
    end else begin
      if (wr_live) regs[wrAddr] <= dataIn;
      pending <= pending_next;
    end
  end

endmodule
